multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RISC-V datapath; successor to the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Adds a memory ready handshake with optional timeout, U-type support, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register opcode field, data memory handshake and ALU zero flag on one side, and datapath mux/enable controls on the other.

Parameters:
- EN_UTYPE, 1: 1 = lui/auipc legal; 0 = they trap.
- WAIT_MAX, 0: maximum cycles a memory state waits for mem_ready before trapping; 0 = wait forever.
- CNT_W, 32: width of the instret counter.

Ports:
- clk in 1: clock; all state changes on rising edge.
- rst_n in 1: synchronous reset, active low.
- op in 7: opcode field of the instruction register.
- zero in 1: ALU zero flag.
- mem_ready in 1: memory access completes this cycle.
- pcWrite out 1: PC register enable.
- adrSrc out 1: memory address mux; 0 = PC, 1 = ALU result register.
- memWrite out 1: data memory write strobe.
- irWrite out 1: instruction register and oldPC enable.
- resSrc out 2: result mux; 00 = aluOut, 01 = memData, 10 = aluResult.
- aluSrcA out 2: ALU A mux; 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- aluSrcB out 2: ALU B mux; 00 = rs2, 01 = imm, 10 = constant 4.
- aluOp out 2: to alu_deco; 00 = add, 01 = sub/branch, 10 = funct-decoded.
- immSrc out 3: immediate format; I = 000, S = 001, B = 010, J = 011, U = 100.
- regWrite out 1: register file write enable.
- trap out 1: sticky illegal-opcode or timeout flag.
- instret out CNT_W: retired-instruction count.

Behaviour:
- Opcode legality:
  - Legal: lw = 3, sw = 35, R = 51, I = 19, beq = 99, jal = 111.
  - lui = 55 and auipc = 23 are legal only when EN_UTYPE = 1.
  - Any other opcode is illegal.
- Outputs are Moore, decoded from state, except:
  - Memory strobes are gated by mem_ready as listed per state.
  - pcWrite = pcUpdate | (branch & zero).
  - immSrc is decoded combinationally from op: lw/I = 000, sw = 001, beq = 010, jal = 011, lui/auipc = 100, other = 000.
- Unlisted controls are 0 in every state.
- States, their outputs and transitions:
  - FETCH: adrSrc = 0, aluSrcA = 00, aluSrcB = 10, aluOp = 00, resSrc = 10. irWrite and pcUpdate are asserted only while mem_ready = 1. Go to DECODE when mem_ready = 1, else stay.
  - DECODE: aluSrcA = 01, aluSrcB = 01, aluOp = 00 (branch target). Next state by op: lw/sw -> MEMADR; R -> EXECUTER; I -> EXECUTEI; beq -> BEQ; jal -> JAL; lui/auipc -> EXECUTEU; illegal -> TRAP.
  - MEMADR: aluSrcA = 10, aluSrcB = 01, aluOp = 00. Go to MEMREAD if lw, else MEMWRITE.
  - MEMREAD: adrSrc = 1. Go to MEMWB on mem_ready = 1, else stay.
  - MEMWB: resSrc = 01, regWrite = 1. Go to FETCH.
  - MEMWRITE: adrSrc = 1, memWrite = 1 held until mem_ready = 1. Go to FETCH on mem_ready = 1.
  - EXECUTER: aluSrcA = 10, aluSrcB = 00, aluOp = 10. Go to ALUWB.
  - EXECUTEI: aluSrcA = 10, aluSrcB = 01, aluOp = 10. Go to ALUWB.
  - EXECUTEU: aluSrcA = 11 (lui) or 01 (auipc), aluSrcB = 01, aluOp = 00. Go to ALUWB.
  - ALUWB: resSrc = 00, regWrite = 1. Go to FETCH.
  - BEQ: aluSrcA = 10, aluSrcB = 00, aluOp = 01, resSrc = 00, branch = 1. Go to FETCH.
  - JAL: aluSrcA = 01, aluSrcB = 10, resSrc = 00, pcUpdate = 1. Go to ALUWB.
  - TRAP: all enables 0, trap = 1. Leaves only on reset.
- Op sampling: op is taken from IR, which is stable after FETCH; DECODE through writeback use the latched op.
- Timeout (WAIT_MAX > 0):
  - A wait counter clears on entry to each of FETCH, MEMREAD and MEMWRITE, and increments each cycle there with mem_ready = 0.
  - When it reaches WAIT_MAX, go to TRAP; no strobe is asserted in the trapping cycle.
- instret:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. JAL counts via ALUWB.
  - Wraps modulo 2^CNT_W. Never increments in TRAP.
- Reset:
  - rst_n sampled low -> state = FETCH, instret = 0, trap = 0, wait counter = 0.
  - While rst_n is low, pcWrite, irWrite, memWrite and regWrite are forced 0.
  - Reset mid-instruction aborts it with no writes and no count.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_AUIPC).
  - The state enum.
  - Encodings for resSrc, aluSrcA, aluSrcB, aluOp and immSrc.
- One natural sub-module: imm_src_deco (combinational op -> immSrc plus a legal flag honouring EN_UTYPE). The FSM, wait counter and instret stay in multicycle_ctrl.

Test Plan:
- Reset, then lw (op = 3) with mem_ready held at 1:
  - States run FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles).
  - regWrite = 1 only in MEMWB; instret = 1 afterwards.
- sw (op = 35) with mem_ready low for 3 cycles in MEMWRITE:
  - memWrite is held 4 cycles and regWrite is never asserted.
  - Back to FETCH; instret increments by 1.
- beq (op = 99) with zero = 1, then again with zero = 0:
  - pcWrite = 1 in BEQ for the first case and 0 for the second.
  - Both take 3 cycles; instret increments by 2 total.
- Illegal op = 127 after FETCH:
  - DECODE -> TRAP; trap = 1 and all enables 0 indefinitely.
  - instret is unchanged; rst_n low for one cycle restores FETCH with trap = 0.
- lui (op = 55) with EN_UTYPE = 1: EXECUTEU with aluSrcA = 11, then ALUWB, regWrite = 1. With EN_UTYPE = 0, the same op goes to TRAP.
- WAIT_MAX = 4 with mem_ready stuck low in FETCH:
  - TRAP is entered after 4 wait cycles.
  - irWrite and pcWrite are never asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath mux encodings for the multicycle controller.
package ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_AUIPC = 7'd23;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StExecU, StAluWb, StBeq, StJal, StTrap
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_deco.sv
// Opcode -> immediate format select, plus opcode legality (U-type gated by EN_UTYPE).
module imm_src_deco
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_UTYPE = 1
) (
    input  logic [6:0] op,
    output logic [2:0] imm_src,
    output logic       legal
);

    always_comb begin
        imm_src = IMM_I;
        legal   = 1'b0;
        case (op)
            OP_LW, OP_I, OP_R: legal = 1'b1;
            OP_SW: begin
                imm_src = IMM_S;
                legal   = 1'b1;
            end
            OP_BEQ: begin
                imm_src = IMM_B;
                legal   = 1'b1;
            end
            OP_JAL: begin
                imm_src = IMM_J;
                legal   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_src = IMM_U;
                legal   = (EN_UTYPE != 0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RISC-V datapath, with memory-ready wait timeout,
// illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_UTYPE = 1,
    parameter int unsigned WAIT_MAX = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic [1:0]       resSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [2:0]       immSrc,
    output logic             regWrite,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WaitW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    state_t           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             legal, wait_state, timeout;
    logic             pc_update, branch, ir_write, mem_write, reg_write;

    imm_src_deco #(
        .EN_UTYPE(EN_UTYPE)
    ) u_imm_src_deco (
        .op     (op),
        .imm_src(immSrc),
        .legal  (legal)
    );

    assign wait_state = (state_q == StFetch) || (state_q == StMemRead) ||
                        (state_q == StMemWrite);
    assign timeout    = (WAIT_MAX != 0) && wait_state && (wait_q == WaitW'(WAIT_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (timeout)        state_d = StTrap;
                else if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                if (!legal) begin
                    state_d = StTrap;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = StMemAdr;
                        OP_R:         state_d = StExecR;
                        OP_I:         state_d = StExecI;
                        OP_BEQ:       state_d = StBeq;
                        OP_JAL:       state_d = StJal;
                        default:      state_d = StExecU;  // only legal lui/auipc remain
                    endcase
                end
            end
            StMemAdr: state_d = (op == OP_LW) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (timeout)        state_d = StTrap;
                else if (mem_ready) state_d = StMemWb;
            end
            StMemWb: state_d = StFetch;
            StMemWrite: begin
                if (timeout)        state_d = StTrap;
                else if (mem_ready) state_d = StFetch;
            end
            StExecR, StExecI, StExecU: state_d = StAluWb;
            StAluWb, StBeq:            state_d = StFetch;
            StJal:                     state_d = StAluWb;
            StTrap:                    state_d = StTrap;
            default:                   state_d = StFetch;
        endcase
    end

    // Counter restarts on every state change so each wait state gets its own budget.
    always_comb begin
        wait_d    = wait_q;
        instret_d = instret_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((WAIT_MAX != 0) && wait_state && !mem_ready && !timeout) begin
            wait_d = wait_q + WaitW'(1);
        end
        if ((state_d == StFetch) && ((state_q == StMemWb) || (state_q == StMemWrite) ||
                                     (state_q == StAluWb) || (state_q == StBeq))) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        adrSrc    = 1'b0;
        resSrc    = RES_ALUOUT;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_ADD;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        trap      = 1'b0;
        unique case (state_q)
            StFetch: begin
                aluSrcB   = SRCB_FOUR;
                resSrc    = RES_ALURESULT;
                ir_write  = mem_ready && !timeout;
                pc_update = mem_ready && !timeout;
            end
            StDecode: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            StMemAdr: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            StMemRead: adrSrc = 1'b1;
            StMemWb: begin
                resSrc    = RES_MEMDATA;
                reg_write = 1'b1;
            end
            StMemWrite: begin
                adrSrc    = 1'b1;
                mem_write = !timeout;
            end
            StExecR: begin
                aluSrcA = SRCA_RS1;
                aluOp   = ALUOP_FUNCT;
            end
            StExecI: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            StExecU: begin
                aluSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            StAluWb: reg_write = 1'b1;
            StBeq: begin
                aluSrcA = SRCA_RS1;
                aluOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            StJal: begin
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            StTrap: trap = 1'b1;
            default: ;
        endcase
        // Strobes are suppressed combinationally while reset is held.
        pcWrite  = rst_n && (pc_update || (branch && zero));
        irWrite  = rst_n && ir_write;
        memWrite = rst_n && mem_write;
        regWrite = rst_n && reg_write;
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: stimulus queues expected control vectors, a negedge monitor compares them.
module tb_multicycle_ctrl;

    typedef enum int {SF, SFT, SD, SMA, SMR, SMWB, SMW, SER, SEI, SEU, SAWB, SBQ, SJ, ST} st_e;

    typedef struct {
        int          idx;
        logic [16:0] vec;
        logic [16:0] mask;
        logic [31:0] cnt;
        logic        chk_cnt;
        string       name;
    } exp_t;

    localparam logic [16:0] EnMask = 17'b1_0_1_1_00_00_00_00_000_1_0;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b000;
    logic [6:0] op = 7'd3;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic        pcw[3], adr[3], memw[3], irw[3], regw[3], tr[3];
    logic [1:0]  res[3], sa[3], sb[3], aop[3];
    logic [2:0]  imm[3];
    logic [31:0] cnt[3];

    exp_t        q[$];
    exp_t        e;
    logic [16:0] act;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut0 (
        .clk(clk), .rst_n(rst[0]), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcw[0]), .adrSrc(adr[0]), .memWrite(memw[0]), .irWrite(irw[0]),
        .resSrc(res[0]), .aluSrcA(sa[0]), .aluSrcB(sb[0]), .aluOp(aop[0]), .immSrc(imm[0]),
        .regWrite(regw[0]), .trap(tr[0]), .instret(cnt[0])
    );

    multicycle_ctrl #(.EN_UTYPE(0)) dut1 (
        .clk(clk), .rst_n(rst[1]), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcw[1]), .adrSrc(adr[1]), .memWrite(memw[1]), .irWrite(irw[1]),
        .resSrc(res[1]), .aluSrcA(sa[1]), .aluSrcB(sb[1]), .aluOp(aop[1]), .immSrc(imm[1]),
        .regWrite(regw[1]), .trap(tr[1]), .instret(cnt[1])
    );

    multicycle_ctrl #(.WAIT_MAX(4)) dut2 (
        .clk(clk), .rst_n(rst[2]), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcw[2]), .adrSrc(adr[2]), .memWrite(memw[2]), .irWrite(irw[2]),
        .resSrc(res[2]), .aluSrcA(sa[2]), .aluSrcB(sb[2]), .aluOp(aop[2]), .immSrc(imm[2]),
        .regWrite(regw[2]), .trap(tr[2]), .instret(cnt[2])
    );

    // Expected outputs per state, straight from the state/output table.
    function automatic logic [16:0] exp_vec(st_e st, logic [6:0] o, logic z, logic mr);
        logic       p, a, m, i, r, t;
        logic [1:0] rs, xa, xb, ao;
        logic [2:0] im;
        {p, a, m, i, r, t} = 6'b0;
        rs = 2'b00; xa = 2'b00; xb = 2'b00; ao = 2'b00;
        case (o)
            7'd35:        im = 3'b001;
            7'd99:        im = 3'b010;
            7'd111:       im = 3'b011;
            7'd55, 7'd23: im = 3'b100;
            default:      im = 3'b000;
        endcase
        case (st)
            SF:   begin xb = 2'b10; rs = 2'b10; i = mr; p = mr; end
            SFT:  begin xb = 2'b10; rs = 2'b10; end
            SD:   begin xa = 2'b01; xb = 2'b01; end
            SMA:  begin xa = 2'b10; xb = 2'b01; end
            SMR:  a = 1'b1;
            SMWB: begin rs = 2'b01; r = 1'b1; end
            SMW:  begin a = 1'b1; m = 1'b1; end
            SER:  begin xa = 2'b10; ao = 2'b10; end
            SEI:  begin xa = 2'b10; xb = 2'b01; ao = 2'b10; end
            SEU:  begin xa = (o == 7'd55) ? 2'b11 : 2'b01; xb = 2'b01; end
            SAWB: r = 1'b1;
            SBQ:  begin xa = 2'b10; ao = 2'b01; p = z; end
            SJ:   begin xa = 2'b01; xb = 2'b10; p = 1'b1; end
            ST:   t = 1'b1;
            default: ;
        endcase
        return {p, a, m, i, rs, xa, xb, ao, im, r, t};
    endfunction

    task automatic cyc(int idx, st_e st, logic [6:0] o, logic z, logic mr, int c, string nm);
        exp_t x;
        op = o; zero = z; mem_ready = mr;
        x.idx = idx; x.vec = exp_vec(st, o, z, mr); x.mask = '1;
        x.cnt = c; x.chk_cnt = 1'b1; x.name = nm;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    // One cycle of reset: only the write strobes are defined, and they must all be 0.
    task automatic rst_cyc(int idx, string nm);
        exp_t x;
        rst[idx] = 1'b0; zero = 1'b1; mem_ready = 1'b1;
        x.idx = idx; x.vec = '0; x.mask = EnMask; x.cnt = 0; x.chk_cnt = 1'b0; x.name = nm;
        q.push_back(x);
        @(posedge clk); #1;
        rst[idx] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {pcw[e.idx], adr[e.idx], memw[e.idx], irw[e.idx], res[e.idx], sa[e.idx],
                   sb[e.idx], aop[e.idx], imm[e.idx], regw[e.idx], tr[e.idx]};
            total++;
            if (((act & e.mask) !== (e.vec & e.mask)) || (e.chk_cnt && cnt[e.idx] !== e.cnt)) begin
                bad++;
                $display("FAIL %s: got ctl=%b instret=%0d, want ctl=%b instret=%0d",
                         e.name, act & e.mask, cnt[e.idx], e.vec & e.mask, e.cnt);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        rst_cyc(0, "reset0");
        // lw, memory always ready
        cyc(0, SF, 3, 0, 1, 0, "lw_fetch");   cyc(0, SD, 3, 0, 1, 0, "lw_decode");
        cyc(0, SMA, 3, 0, 1, 0, "lw_memadr"); cyc(0, SMR, 3, 0, 1, 0, "lw_memread");
        cyc(0, SMWB, 3, 0, 1, 0, "lw_memwb");
        // sw with three not-ready cycles
        cyc(0, SF, 35, 0, 1, 1, "sw_fetch");  cyc(0, SD, 35, 0, 1, 1, "sw_decode");
        cyc(0, SMA, 35, 0, 1, 1, "sw_memadr");
        for (int i = 0; i < 3; i++) cyc(0, SMW, 35, 0, 0, 1, "sw_wait");
        cyc(0, SMW, 35, 0, 1, 1, "sw_done");
        // beq taken then not taken
        cyc(0, SF, 99, 1, 1, 2, "beq1_fetch"); cyc(0, SD, 99, 1, 1, 2, "beq1_decode");
        cyc(0, SBQ, 99, 1, 1, 2, "beq1_taken");
        cyc(0, SF, 99, 0, 1, 3, "beq0_fetch"); cyc(0, SD, 99, 0, 1, 3, "beq0_decode");
        cyc(0, SBQ, 99, 0, 1, 3, "beq0_nottaken");
        // jal, R, I, lui, auipc
        cyc(0, SF, 111, 0, 1, 4, "jal_fetch"); cyc(0, SD, 111, 0, 1, 4, "jal_decode");
        cyc(0, SJ, 111, 0, 1, 4, "jal_jal");   cyc(0, SAWB, 111, 0, 1, 4, "jal_aluwb");
        cyc(0, SF, 51, 0, 1, 5, "r_fetch");    cyc(0, SD, 51, 0, 1, 5, "r_decode");
        cyc(0, SER, 51, 0, 1, 5, "r_exec");    cyc(0, SAWB, 51, 0, 1, 5, "r_aluwb");
        cyc(0, SF, 19, 0, 1, 6, "i_fetch");    cyc(0, SD, 19, 0, 1, 6, "i_decode");
        cyc(0, SEI, 19, 0, 1, 6, "i_exec");    cyc(0, SAWB, 19, 0, 1, 6, "i_aluwb");
        cyc(0, SF, 55, 0, 1, 7, "lui_fetch");  cyc(0, SD, 55, 0, 1, 7, "lui_decode");
        cyc(0, SEU, 55, 0, 1, 7, "lui_exec");  cyc(0, SAWB, 55, 0, 1, 7, "lui_aluwb");
        cyc(0, SF, 23, 0, 1, 8, "auipc_fetch"); cyc(0, SD, 23, 0, 1, 8, "auipc_decode");
        cyc(0, SEU, 23, 0, 1, 8, "auipc_exec"); cyc(0, SAWB, 23, 0, 1, 8, "auipc_aluwb");
        // illegal opcode traps until reset
        cyc(0, SF, 127, 0, 1, 9, "ill_fetch"); cyc(0, SD, 127, 0, 1, 9, "ill_decode");
        for (int i = 0; i < 3; i++) cyc(0, ST, 127, 1, 1, 9, "ill_trap");
        rst_cyc(0, "trap_reset");
        cyc(0, SF, 3, 0, 1, 0, "post_trap_fetch"); cyc(0, SD, 3, 0, 1, 0, "abort_decode");
        cyc(0, SMA, 3, 0, 1, 0, "abort_memadr");   cyc(0, SMR, 3, 0, 1, 0, "abort_memread");
        rst_cyc(0, "abort_in_memwb");
        cyc(0, SF, 3, 0, 1, 0, "abort_fetch");

        // U-type disabled: lui traps
        rst_cyc(1, "reset1");
        cyc(1, SF, 55, 0, 1, 0, "nou_fetch"); cyc(1, SD, 55, 0, 1, 0, "nou_decode");
        cyc(1, ST, 55, 0, 1, 0, "nou_trap");  cyc(1, ST, 55, 0, 1, 0, "nou_trap_hold");

        // WAIT_MAX = 4: four idle fetch cycles, then the timeout cycle blocks even a late ready
        rst_cyc(2, "reset2");
        for (int i = 0; i < 4; i++) cyc(2, SF, 3, 0, 0, 0, "tmo_wait");
        cyc(2, SFT, 3, 0, 1, 0, "tmo_gate");
        cyc(2, ST, 3, 0, 1, 0, "tmo_trap");  cyc(2, ST, 3, 0, 1, 0, "tmo_trap_hold");
        rst_cyc(2, "reset2b");
        cyc(2, SF, 3, 0, 1, 0, "w_fetch");   cyc(2, SD, 3, 0, 1, 0, "w_decode");
        cyc(2, SMA, 3, 0, 1, 0, "w_memadr");
        for (int i = 0; i < 3; i++) cyc(2, SMR, 3, 0, 0, 0, "w_memread_wait");
        cyc(2, SMR, 3, 0, 1, 0, "w_memread_done"); cyc(2, SMWB, 3, 0, 1, 0, "w_memwb");
        for (int i = 0; i < 3; i++) cyc(2, SF, 3, 0, 0, 1, "w_fetch_wait");
        cyc(2, SF, 3, 0, 1, 1, "w_fetch_done");   cyc(2, SD, 3, 0, 1, 1, "w_decode2");

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
